// File: rtl/param_fifo.sv
// First-word-fall-through FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Head word is visible with no read latency. When full, a write either replaces the oldest word or is dropped, and either outcome sets overflow.
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit OVERWRITE  = 1'b1,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  read,
    input  logic                  clearErr,
    input  logic [DATA_WIDTH-1:0] inputBus,
    output logic [DATA_WIDTH-1:0] outputBus,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almostEmpty,
    output logic                  almostFull,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_en, rd_adv;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almostEmpty = (count_q <= AE_C);
    assign almostFull  = (count_q >= AF_C);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign outputBus   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_en    = 1'b0;
        rd_adv   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A simultaneous read frees the slot, so a full write only needs the policy when reading is idle.
        wr_en  = write && (!full || read || OVERWRITE);
        rd_adv = (read && !empty) || (write && !read && full && OVERWRITE);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_en, rd_adv})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A fresh error event in the same cycle as clearErr keeps the flag set.
        overflow_d  = (write && !read && full) || (overflow_q && !clearErr);
        underflow_d = (read && empty) || (underflow_q && !clearErr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= inputBus;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Drives one reject-mode and one overwrite-mode FIFO with identical stimulus and
// compares both against queue-based models of the documented push/pop rules.
module tb_param_fifo;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr, rd, clr;
    logic [7:0] din;

    logic [7:0] d0_obus, d1_obus;
    logic [3:0] d0_cnt,  d1_cnt;
    logic d0_e, d0_f, d0_ae, d0_af, d0_ov, d0_un;
    logic d1_e, d1_f, d1_ae, d1_af, d1_ov, d1_un;

    param_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .OVERWRITE(1'b0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_rej (
        .clk(clk), .reset(rst), .write(wr), .read(rd), .clearErr(clr), .inputBus(din),
        .outputBus(d0_obus), .count(d0_cnt), .empty(d0_e), .full(d0_f),
        .almostEmpty(d0_ae), .almostFull(d0_af), .overflow(d0_ov), .underflow(d0_un)
    );

    param_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .OVERWRITE(1'b1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_ovw (
        .clk(clk), .reset(rst), .write(wr), .read(rd), .clearErr(clr), .inputBus(din),
        .outputBus(d1_obus), .count(d1_cnt), .empty(d1_e), .full(d1_f),
        .almostEmpty(d1_ae), .almostFull(d1_af), .overflow(d1_ov), .underflow(d1_un)
    );

    typedef logic [7:0] byte_q_t[$];
    byte_q_t mq [2];
    bit      m_ov [2];
    bit      m_un [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Index 0 rejects writes when full, index 1 drops the oldest word instead.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int s;
            bit os, us;
            s = mq[m].size();
            if (rst) begin
                mq[m].delete();
                m_ov[m] = 1'b0;
                m_un[m] = 1'b0;
            end else begin
                os = wr && !rd && (s == DEPTH);
                us = rd && (s == 0);
                if (rd && s > 0) void'(mq[m].pop_front());
                if (wr) begin
                    if (s < DEPTH || rd) begin
                        mq[m].push_back(din);
                    end else if (m == 1) begin
                        void'(mq[m].pop_front());
                        mq[m].push_back(din);
                    end
                end
                m_ov[m] = os || (m_ov[m] && !clr);
                m_un[m] = us || (m_un[m] && !clr);
            end
        end
    endtask

    task automatic compare_dut(input int m, input logic [7:0] obus, input logic [3:0] cnt,
                               input logic e, input logic f, input logic ae, input logic af,
                               input logic ov, input logic un);
        int s;
        logic [7:0] head;
        s    = mq[m].size();
        head = (s > 0) ? mq[m][0] : 8'h00;
        check_eq($sformatf("m%0d_count", m), 32'(cnt), 32'(s));
        check_eq($sformatf("m%0d_obus", m), 32'(obus), 32'(head));
        check_eq($sformatf("m%0d_empty", m), 32'(e), 32'(s == 0));
        check_eq($sformatf("m%0d_full", m), 32'(f), 32'(s == DEPTH));
        check_eq($sformatf("m%0d_aempty", m), 32'(ae), 32'(s <= AE));
        check_eq($sformatf("m%0d_afull", m), 32'(af), 32'(s >= AF));
        check_eq($sformatf("m%0d_ovf", m), 32'(ov), 32'(m_ov[m]));
        check_eq($sformatf("m%0d_unf", m), 32'(un), 32'(m_un[m]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_dut(0, d0_obus, d0_cnt, d0_e, d0_f, d0_ae, d0_af, d0_ov, d0_un);
        compare_dut(1, d1_obus, d1_cnt, d1_e, d1_f, d1_ae, d1_af, d1_ov, d1_un);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;

        // Reset state
        step(); step();
        check_eq("rst_obus", 32'(d1_obus), 32'h00);
        check_eq("rst_aempty", 32'(d0_ae), 32'h1);
        rst = 1'b0;

        // Single word in, single word out
        wr = 1'b1; din = 8'h0F; step(); wr = 1'b0;
        check_eq("one_obus", 32'(d0_obus), 32'h0F);
        rd = 1'b1; step(); rd = 1'b0;
        check_eq("one_empty", 32'(d1_e), 32'h1);

        // Nine writes into an eight-deep FIFO, then drain
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; din = 8'(i); step();
        end
        wr = 1'b0;
        check_eq("ovw_head", 32'(d1_obus), 32'h01);
        check_eq("rej_head", 32'(d0_obus), 32'h00);
        check_eq("rej_ovf", 32'(d0_ov), 32'h1);
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1; step();
        end
        rd = 1'b0;

        // Underflow, clear, and set-wins-over-clear
        clr = 1'b1; step(); clr = 1'b0;
        rd = 1'b1; step(); rd = 1'b0;
        check_eq("unf_set", 32'(d0_un), 32'h1);
        clr = 1'b1; step();
        check_eq("unf_clr", 32'(d1_un), 32'h0);
        rd = 1'b1; step();
        rd = 1'b0; clr = 1'b0;
        check_eq("unf_setwins", 32'(d1_un), 32'h1);
        clr = 1'b1; step(); clr = 1'b0;

        // Full with simultaneous read+write, then reset mid-stream
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; din = 8'(i); step();
        end
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; rd = 1'b1; din = 8'hA0 + 8'(i); step();
        end
        check_eq("wr_rd_full_head", 32'(d0_obus), 32'h03);
        check_eq("wr_rd_full_ovf", 32'(d1_ov), 32'h0);
        wr = 1'b1; rd = 1'b0; din = 8'h55; rst = 1'b1; step();
        rst = 1'b0; wr = 1'b0;
        check_eq("midrst_cnt", 32'(d1_cnt), 32'h0);

        // Randomised traffic with shifting write/read bias to hit both full and empty
        for (int i = 0; i < 4000; i++) begin
            int ph;
            ph  = (i / 150) % 3;
            wr  = ($urandom_range(99) < (ph == 0 ? 80 : (ph == 1 ? 50 : 20)));
            rd  = ($urandom_range(99) < (ph == 0 ? 20 : (ph == 1 ? 50 : 80)));
            clr = ($urandom_range(99) < 5);
            rst = ($urandom_range(999) < 3);
            din = 8'($urandom);
            step();
        end
        rst = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
